data_memory_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory request interface, i.e. the consumer of MemEn, MemWrite, ByteEn and TruncSrc.
- Owns a word-addressed data RAM and applies lane-shifted byte-enable writes.
- Returns loads truncated and sign- or zero-extended per TruncSrc.
- Enforces a fixed multi-cycle access latency with a ready/valid handshake, so the pipeline stalls on ReqReady and consumes RespValid.

---
 rtl/data_memory_responder.sv | 179 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed RAM behind a ready/valid request port.
// It applies lane-shifted byte-enable stores and returns truncated, extended loads.
// Each access takes a fixed number of cycles.

package HighLevelControl;
    typedef enum logic [2:0] {
        BYTE,
        HALF_WORD,
        WORD,
        BYTE_UNSIGNED,
        HALF_WORD_UNSIGNED,
        NONE
    } truncSrc;
endpackage

module data_memory_responder #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemEn,
    input  logic                          MemWrite,
    input  logic [WORD_SIZE/8-1:0]        ByteEn,
    input  logic [WORD_SIZE-1:0]          Addr,
    input  logic [WORD_SIZE-1:0]          WriteData,
    input  HighLevelControl::truncSrc     TruncSrc,
    output logic                          ReqReady,
    output logic                          RespValid,
    output logic [WORD_SIZE-1:0]          ReadData,
    output logic                          MisalignedFault
);
    import HighLevelControl::*;

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned NB   = WORD_SIZE / 8;

    // Access size codes shared by the store and load alignment checks.
    localparam logic [1:0] SzNone = 2'd0;
    localparam logic [1:0] SzByte = 2'd1;
    localparam logic [1:0] SzHalf = 2'd2;
    localparam logic [1:0] SzWord = 2'd3;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;
    logic                 w_accept;

    logic                 r_we;
    logic [NB-1:0]        r_be;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    truncSrc              r_trunc;

    logic [WORD_SIZE-1:0] r_mem [DEPTH_WORDS];

    logic [IdxW-1:0]      w_idx;
    logic [1:0]           w_off;
    logic [1:0]           w_size;
    logic                 w_fault;
    logic                 w_resp;
    logic                 w_mem_we;
    logic [NB-1:0]        w_wmask;
    logic [WORD_SIZE-1:0] w_wdata;
    logic [WORD_SIZE-1:0] w_word;
    logic [WORD_SIZE-1:0] w_shifted;
    logic [WORD_SIZE-1:0] w_load;
    logic                 w_unused_addr;

    assign w_idx         = r_addr[IdxW+1:2];
    assign w_off         = r_addr[1:0];
    // Upper address bits are dropped so addresses wrap around the RAM.
    assign w_unused_addr = ^r_addr[WORD_SIZE-1:IdxW+2];

    // State register and counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request capture; inputs are don't-care once accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= MemWrite;
            r_be    <= ByteEn;
            r_addr  <= Addr;
            r_wdata <= WriteData;
            r_trunc <= TruncSrc;
        end
    end

    // Next-state logic: IDLE accepts, BUSY counts down, RESP lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MemEn && !reset) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = 4'(LATENCY - 1);
                    w_state_next = (LATENCY == 1) ? StResp : StBusy;
                end
            end
            StBusy: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_next = StResp;
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Access size is taken from the lane mask for stores and from TruncSrc for loads.
    always_comb begin
        w_size = SzWord;
        if (r_we) begin
            if (r_be == NB'(0))      w_size = SzNone;
            else if (r_be == NB'(1)) w_size = SzByte;
            else if (r_be == NB'(3)) w_size = SzHalf;
            else                     w_size = SzWord;
        end else begin
            case (r_trunc)
                BYTE, BYTE_UNSIGNED:           w_size = SzByte;
                HALF_WORD, HALF_WORD_UNSIGNED: w_size = SzHalf;
                default:                       w_size = SzWord;
            endcase
        end
        w_fault = ((w_size == SzHalf) && w_off[0]) || ((w_size == SzWord) && (w_off != 2'd0));
    end

    // Load path: select the addressed lane, then truncate and extend.
    always_comb begin
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_off, 3'b000};
        case (r_trunc)
            BYTE:               w_load = {{(WORD_SIZE-8){w_shifted[7]}}, w_shifted[7:0]};
            BYTE_UNSIGNED:      w_load = {{(WORD_SIZE-8){1'b0}}, w_shifted[7:0]};
            HALF_WORD:          w_load = {{(WORD_SIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            HALF_WORD_UNSIGNED: w_load = {{(WORD_SIZE-16){1'b0}}, w_shifted[15:0]};
            default:            w_load = w_word;
        endcase
    end

    // Handshake outputs; everything is forced quiet while reset is held.
    always_comb begin
        w_resp          = (r_state == StResp) && !reset;
        ReqReady        = (r_state == StIdle) && !reset;
        RespValid       = w_resp;
        MisalignedFault = w_resp && w_fault;
        ReadData        = (w_resp && !r_we && !w_fault) ? w_load : '0;
        w_wmask         = NB'(r_be << w_off);
        w_wdata         = r_wdata << {w_off, 3'b000};
        w_mem_we        = w_resp && r_we && !w_fault;
    end

    // Store commits on the edge that ends RESP, enabled lanes only.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a queue-based response scoreboard.
module tb_data_memory_responder;
    import HighLevelControl::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemEn;
    logic        MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    truncSrc     TruncSrc;
    logic        ReqReady;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        MisalignedFault;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    data_memory_responder #(
        .WORD_SIZE  (32),
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .MemEn          (MemEn),
        .MemWrite       (MemWrite),
        .ByteEn         (ByteEn),
        .Addr           (Addr),
        .WriteData      (WriteData),
        .TruncSrc       (TruncSrc),
        .ReqReady       (ReqReady),
        .RespValid      (RespValid),
        .ReadData       (ReadData),
        .MisalignedFault(MisalignedFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (RespValid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got data 0x%08h fault %0b with no request pending",
                         ReadData, MisalignedFault);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (ReadData !== e.data || MisalignedFault !== e.fault) begin
                    n_errors++;
                    $display("FAIL %s: got data 0x%08h fault %0b expected data 0x%08h fault %0b",
                             e.name, ReadData, MisalignedFault, e.data, e.fault);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ReqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ReqReady) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_ready_timeout: ReqReady still 0 after %0d cycles", name, n);
        end
    endtask

    // Issue one request, queue its expected response, then check handshake timing.
    task automatic req(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input truncSrc tr,
                       input logic [31:0] exp_d, input logic exp_f, input string name);
        exp_t e;
        int   low;
        int   resp_k;
        wait_ready(name);
        MemEn     = 1'b1;
        MemWrite  = we;
        ByteEn    = be;
        Addr      = a;
        WriteData = wd;
        TruncSrc  = tr;
        e.data    = exp_d;
        e.fault   = exp_f;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        MemEn     = 1'b0;
        Addr      = 32'hxxxx_xxxx;
        WriteData = 32'hxxxx_xxxx;
        low       = 0;
        resp_k    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (RespValid) resp_k = k;
            if (ReqReady) break;
            low++;
        end
        check({name, "_ready_low_cycles"}, low, 2);
        check({name, "_resp_cycle"}, resp_k, 2);
    endtask

    // Accept a store, then reset partway through; nothing may commit or respond.
    task automatic abandon(input int delay_cycles, input string name);
        wait_ready(name);
        MemEn     = 1'b1;
        MemWrite  = 1'b1;
        ByteEn    = 4'b1111;
        Addr      = 32'h20;
        WriteData = 32'hFFFF_FFFF;
        TruncSrc  = WORD;
        @(posedge clk);
        #1;
        MemEn = 1'b0;
        for (int i = 0; i < delay_cycles; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check({name, "_rst_ready"}, ReqReady, 0);
        check({name, "_rst_valid"}, RespValid, 0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_rst_ready2"}, ReqReady, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({name, "_ready_after_rst"}, ReqReady, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        MemEn     = 1'b0;
        MemWrite  = 1'b0;
        ByteEn    = 4'b0000;
        Addr      = 32'h0;
        WriteData = 32'h0;
        TruncSrc  = WORD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", ReqReady, 0);
        check("reset_valid", RespValid, 0);
        check("reset_rdata", ReadData, 0);
        check("reset_fault", MisalignedFault, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ReqReady, 1);

        req(1, 4'b1111, 32'h10, 32'hDEAD_BEEF, WORD, 32'h0, 0, "sw_10");
        req(0, 4'b0000, 32'h10, 32'h0, WORD, 32'hDEAD_BEEF, 0, "lw_10_a");

        req(1, 4'b0001, 32'h11, 32'h0000_00AA, WORD, 32'h0, 0, "sb_11");
        req(0, 4'b0000, 32'h11, 32'h0, BYTE, 32'hFFFF_FFAA, 0, "lb_11");
        req(0, 4'b0000, 32'h11, 32'h0, BYTE_UNSIGNED, 32'h0000_00AA, 0, "lbu_11");
        req(0, 4'b0000, 32'h10, 32'h0, WORD, 32'hDEAD_AAEF, 0, "lw_10_b");

        req(1, 4'b0011, 32'h12, 32'h0000_8001, WORD, 32'h0, 0, "sh_12");
        req(0, 4'b0000, 32'h12, 32'h0, HALF_WORD, 32'hFFFF_8001, 0, "lh_12");
        req(0, 4'b0000, 32'h12, 32'h0, HALF_WORD_UNSIGNED, 32'h0000_8001, 0, "lhu_12");
        req(0, 4'b0000, 32'h10, 32'h0, WORD, 32'h8001_AAEF, 0, "lw_10_c");

        req(1, 4'b1111, 32'h13, 32'h5555_5555, WORD, 32'h0, 1, "sw_13_fault");
        req(0, 4'b0000, 32'h11, 32'h0, HALF_WORD, 32'h0, 1, "lh_11_fault");
        req(0, 4'b0000, 32'h12, 32'h0, WORD, 32'h0, 1, "lw_12_fault");
        req(1, 4'b0011, 32'h11, 32'h0000_1234, WORD, 32'h0, 1, "sh_11_fault");
        req(1, 4'b0000, 32'h10, 32'h0BAD_0BAD, WORD, 32'h0, 0, "s_empty_mask");
        req(0, 4'b0000, 32'h10, 32'h0, WORD, 32'h8001_AAEF, 0, "lw_10_d");
        req(0, 4'b0000, 32'h13, 32'h0, BYTE, 32'hFFFF_FF80, 0, "lb_13");
        req(0, 4'b0000, 32'h10, 32'h0, NONE, 32'h8001_AAEF, 0, "lnone_10");

        req(1, 4'b1111, 32'h400, 32'h1234_5678, WORD, 32'h0, 0, "sw_400_wrap");
        req(0, 4'b0000, 32'h0, 32'h0, WORD, 32'h1234_5678, 0, "lw_0_wrap");

        req(1, 4'b1111, 32'h20, 32'h0BAD_F00D, WORD, 32'h0, 0, "sw_20");
        abandon(0, "abandon_busy");
        abandon(1, "abandon_resp");
        req(0, 4'b0000, 32'h20, 32'h0, WORD, 32'h0BAD_F00D, 0, "lw_20_after_rst");

        repeat (5) @(negedge clk);
        check("pending_responses", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
